load_store_unit: RTL and testbench

Initiator side of the data-memory port. Accepts one load or store at a time from the execute stage, converts the byte address into word-addressed memory accesses with byte enables and lane-shifted write data, and sign- or zero-extends load data. Splits a misaligned access that crosses a word boundary into two word accesses. Returns a single one-cycle response to the pipeline.

---
 rtl/load_store_unit.sv | 199 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator: byte loads/stores to word accesses, split on word crossing
module load_store_unit #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_type,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC1,
        S_ACC2,
        S_FIN,
        S_RESP
    } state_t;

    state_t state, next_state;

    logic [1:0]        req_off;
    logic [3:0]        size_mask;
    logic [7:0]        req_mask;
    logic [63:0]       req_data64;
    logic              req_split;
    logic              range_bad;
    logic              type_bad;
    logic              req_fault;
    logic              accept;
    logic [ADDR_W-1:0] req_w0;

    logic              store_q;
    logic [2:0]        type_q;
    logic [1:0]        off_q;
    logic              split_q;
    logic [ADDR_W-1:0] w1_q;
    logic [3:0]        mask_hi_q;
    logic [31:0]       wdata_hi_q;
    logic [31:0]       word0_q;

    logic [63:0]       load_pair;
    logic [31:0]       load_shifted;
    logic [31:0]       load_result;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign req_off   = req_addr[1:0];
    assign req_w0    = req_addr[ADDR_W+1:2];

    always_comb begin
        size_mask = 4'b1111;
        case (req_type[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    // Byte lanes above bit 3 of the mask belong to the following word.
    assign req_mask   = {4'b0000, size_mask} << req_off;
    assign req_data64 = {32'd0, req_wdata} << {req_off, 3'b000};
    assign req_split  = |req_mask[7:4];

    assign range_bad = (req_addr >> (ADDR_W + 2)) != 32'd0;
    assign type_bad  = (req_type == 3'b011) || (req_type[2:1] == 2'b11) ||
                       (req_store && req_type[2]);
    assign req_fault = range_bad || type_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = req_fault ? S_RESP : S_ACC1;
                end
            end
            S_ACC1: begin
                if (split_q) begin
                    next_state = S_ACC2;
                end else begin
                    next_state = store_q ? S_RESP : S_FIN;
                end
            end
            S_ACC2:  next_state = store_q ? S_RESP : S_FIN;
            S_FIN:   next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // The last word read arrives during FIN; word0 was captured during ACC2 for splits.
    assign load_pair    = split_q ? {mem_rdata, word0_q} : {32'd0, mem_rdata};
    assign load_shifted = 32'(load_pair >> {off_q, 3'b000});

    always_comb begin
        load_result = load_shifted;
        case (type_q)
            3'b000:  load_result = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b001:  load_result = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b100:  load_result = {24'd0, load_shifted[7:0]};
            3'b101:  load_result = {16'd0, load_shifted[15:0]};
            default: load_result = load_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q    <= 1'b0;
            type_q     <= 3'd0;
            off_q      <= 2'd0;
            split_q    <= 1'b0;
            w1_q       <= '0;
            mask_hi_q  <= 4'd0;
            wdata_hi_q <= 32'd0;
            word0_q    <= 32'd0;
        end else begin
            if (accept) begin
                store_q    <= req_store;
                type_q     <= req_type;
                off_q      <= req_off;
                split_q    <= req_split;
                w1_q       <= req_w0 + ADDR_W'(1);
                mask_hi_q  <= req_mask[7:4];
                wdata_hi_q <= req_data64[63:32];
            end
            if (state == S_ACC2 && !store_q) begin
                word0_q <= mem_rdata;
            end
        end
    end

    // Memory port is registered: values are loaded on the edge entering ACC1/ACC2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            if (state == S_IDLE && next_state == S_ACC1) begin
                mem_en    <= 1'b1;
                mem_we    <= req_store;
                mem_addr  <= req_w0;
                mem_be    <= req_mask[3:0];
                mem_wdata <= req_data64[31:0];
            end else if (next_state == S_ACC2) begin
                mem_en    <= 1'b1;
                mem_we    <= store_q;
                mem_addr  <= w1_q;
                mem_be    <= mask_hi_q;
                mem_wdata <= wdata_hi_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            resp_valid <= (next_state == S_RESP);
            resp_fault <= (state == S_IDLE) && (next_state == S_RESP);
            if (state == S_FIN) begin
                resp_rdata <= load_result;
            end else if (state != S_RESP && next_state == S_RESP) begin
                resp_rdata <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit: vector table, random ops, reset abort
module tb_load_store_unit;

    localparam int ADDR_W = 17;
    localparam int NWORDS = 1 << ADDR_W;
    localparam logic [31:0] BYTE_MASK = (32'd1 << (ADDR_W + 2)) - 32'd1;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_type;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_fault;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_type   (req_type),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem_arr [0:NWORDS-1];
    logic [31:0] mem_ref [0:NWORDS-1];

    int          acc_n;
    logic [31:0] acc_addr [0:1];
    logic [3:0]  acc_be   [0:1];
    logic [31:0] acc_wd   [0:1];

    int errors = 0;
    int checks = 0;

    always @(posedge clk) begin
        if (mem_en) begin
            if (acc_n < 2) begin
                acc_addr[acc_n] = 32'(mem_addr);
                acc_be[acc_n]   = mem_be;
                acc_wd[acc_n]   = mem_wdata;
            end
            acc_n = acc_n + 1;
        end
        if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem_arr[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
        if (mem_en && !mem_we) mem_rdata <= mem_arr[mem_addr];
        else mem_rdata <= $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Byte-level reference: assemble size bytes little-endian, wrapping at top of memory.
    task automatic model(input logic st, input logic [2:0] ty, input logic [31:0] addr,
                         input logic [31:0] wd, output logic flt, output logic [31:0] rd,
                         output int lat, output int nacc);
        int size;
        int off;
        logic split;
        logic [31:0] v;
        logic [31:0] ba;
        flt = (addr > BYTE_MASK) || ty == 3'd3 || ty == 3'd6 || ty == 3'd7 ||
              (st && (ty == 3'd4 || ty == 3'd5));
        size = (ty[1:0] == 2'd0) ? 1 : (ty[1:0] == 2'd1) ? 2 : 4;
        off = int'(addr & 32'd3);
        split = (off + size) > 4;
        rd = 32'd0;
        if (flt) begin
            lat = 1;
            nacc = 0;
            return;
        end
        nacc = split ? 2 : 1;
        if (st) begin
            lat = split ? 3 : 2;
            for (int i = 0; i < size; i++) begin
                ba = (addr + 32'(i)) & BYTE_MASK;
                mem_ref[ba >> 2][8*(ba & 3) +: 8] = wd[8*i +: 8];
            end
        end else begin
            lat = split ? 4 : 3;
            v = 32'd0;
            for (int i = 0; i < size; i++) begin
                ba = (addr + 32'(i)) & BYTE_MASK;
                v[8*i +: 8] = mem_ref[ba >> 2][8*(ba & 3) +: 8];
            end
            if (size == 1) rd = ty[2] ? v & 32'hFF : ((v & 32'h80) != 0 ? v | 32'hFFFFFF00 : v);
            else if (size == 2) rd = ty[2] ? v & 32'hFFFF : ((v & 32'h8000) != 0 ? v | 32'hFFFF0000 : v);
            else rd = v;
        end
    endtask

    task automatic run_op(input logic st, input logic [2:0] ty, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic flt);
        @(negedge clk);
        acc_n = 0;
        req_valid = 1'b1;
        req_store = st;
        req_type  = ty;
        req_addr  = addr;
        req_wdata = wd;
        chk("ready_before_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_type  = 3'($urandom);
        req_store = 1'($urandom);
        lat = 0;
        rd = 32'hx;
        flt = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k;
                rd = resp_rdata;
                flt = resp_fault;
                break;
            end
        end
        if (lat == 0) begin
            errors++;
            checks++;
            $display("FAIL resp_timeout: no resp_valid within 8 cycles");
            return;
        end
        @(negedge clk);
        chk("resp_one_cycle", 32'(resp_valid), 32'd0);
        chk("ready_after_resp", 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        string       name;
        logic        st;
        logic [2:0]  ty;
        logic [31:0] addr;
        logic [31:0] wd;
        int          pa0;
        logic [31:0] pd0;
        int          pa1;
        logic [31:0] pd1;
        int          lat;
        logic [31:0] rd;
        logic        flt;
        int          nacc;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int lat;
        int e_lat;
        int e_nacc;
        logic [31:0] rd;
        logic [31:0] e_rd;
        logic flt;
        logic e_flt;
        logic st;
        logic [2:0] ty;
        logic [31:0] addr;
        logic [31:0] wd;
        int wa0;
        int wa1;
        logic [31:0] saved;

        vecs[0] = '{"lw_aligned", 0, 3'b010, 32'h10, 32'h0, 4, 32'hDEADBEEF, 4, 32'hDEADBEEF,
                    3, 32'hDEADBEEF, 0, 1, 32'd4, 4'b1111, 32'h0, 32'd0, 4'b0, 32'h0};
        vecs[1] = '{"lb_sign", 0, 3'b000, 32'h13, 32'h0, 4, 32'h80FF0000, 4, 32'h80FF0000,
                    3, 32'hFFFFFF80, 0, 1, 32'd4, 4'b1000, 32'h0, 32'd0, 4'b0, 32'h0};
        vecs[2] = '{"lbu_zero", 0, 3'b100, 32'h13, 32'h0, 4, 32'h80FF0000, 4, 32'h80FF0000,
                    3, 32'h00000080, 0, 1, 32'd4, 4'b1000, 32'h0, 32'd0, 4'b0, 32'h0};
        vecs[3] = '{"sh_off2", 1, 3'b001, 32'h06, 32'h0000ABCD, 1, 32'h0, 1, 32'h0,
                    2, 32'h0, 0, 1, 32'd1, 4'b1100, 32'hABCD0000, 32'd0, 4'b0, 32'h0};
        vecs[4] = '{"lw_split", 0, 3'b010, 32'h0E, 32'h0, 3, 32'h44332211, 4, 32'h88776655,
                    4, 32'h66554433, 0, 2, 32'd3, 4'b1100, 32'h0, 32'd4, 4'b0011, 32'h0};
        vecs[5] = '{"sw_split_wrap", 1, 3'b010, BYTE_MASK, 32'h11223344, 0, 32'h0, NWORDS-1, 32'h0,
                    3, 32'h0, 0, 2, 32'(NWORDS-1), 4'b1000, 32'h44000000, 32'd0, 4'b0111, 32'h00112233};
        vecs[6] = '{"lw_range_fault", 0, 3'b010, 32'h00080000, 32'h0, 0, 32'h0, 0, 32'h0,
                    1, 32'h0, 1, 0, 32'd0, 4'b0, 32'h0, 32'd0, 4'b0, 32'h0};
        vecs[7] = '{"store_type4_fault", 1, 3'b100, 32'h20, 32'h55, 0, 32'h0, 0, 32'h0,
                    1, 32'h0, 1, 0, 32'd0, 4'b0, 32'h0, 32'd0, 4'b0, 32'h0};
        vecs[8] = '{"lhu_split", 0, 3'b101, 32'h13, 32'h0, 4, 32'h80FF0000, 5, 32'h000000C3,
                    4, 32'h0000C380, 0, 2, 32'd4, 4'b1000, 32'h0, 32'd5, 4'b0001, 32'h0};
        vecs[9] = '{"sb_off1", 1, 3'b000, 32'h21, 32'hFFFFFF5A, 8, 32'h0, 8, 32'h0,
                    2, 32'h0, 0, 1, 32'd8, 4'b0010, 32'h00005A00, 32'd0, 4'b0, 32'h0};

        for (int i = 0; i < NWORDS; i++) begin
            mem_arr[i] = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0F0F;
            mem_ref[i] = mem_arr[i];
        end

        acc_n = 0;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_type  = 3'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_fault", 32'(resp_fault), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            mem_arr[vecs[i].pa0] = vecs[i].pd0;
            mem_ref[vecs[i].pa0] = vecs[i].pd0;
            mem_arr[vecs[i].pa1] = vecs[i].pd1;
            mem_ref[vecs[i].pa1] = vecs[i].pd1;
            model(vecs[i].st, vecs[i].ty, vecs[i].addr, vecs[i].wd, e_flt, e_rd, e_lat, e_nacc);
            run_op(vecs[i].st, vecs[i].ty, vecs[i].addr, vecs[i].wd, lat, rd, flt);
            chk({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].rd);
            chk({vecs[i].name, "_fault"}, 32'(flt), 32'(vecs[i].flt));
            chk({vecs[i].name, "_naccess"}, 32'(acc_n), 32'(vecs[i].nacc));
            if (vecs[i].nacc >= 1) begin
                chk({vecs[i].name, "_addr0"}, acc_addr[0], vecs[i].a0);
                chk({vecs[i].name, "_be0"}, 32'(acc_be[0]), 32'(vecs[i].be0));
                chk({vecs[i].name, "_wdata0"}, acc_wd[0] & {{8{vecs[i].be0[3]}}, {8{vecs[i].be0[2]}},
                    {8{vecs[i].be0[1]}}, {8{vecs[i].be0[0]}}}, vecs[i].wd0);
            end
            if (vecs[i].nacc == 2) begin
                chk({vecs[i].name, "_addr1"}, acc_addr[1], vecs[i].a1);
                chk({vecs[i].name, "_be1"}, 32'(acc_be[1]), 32'(vecs[i].be1));
                chk({vecs[i].name, "_wdata1"}, acc_wd[1] & {{8{vecs[i].be1[3]}}, {8{vecs[i].be1[2]}},
                    {8{vecs[i].be1[1]}}, {8{vecs[i].be1[0]}}}, vecs[i].wd1);
            end
        end

        for (int n = 0; n < 400; n++) begin
            st = 1'($urandom);
            ty = 3'($urandom);
            if ($urandom_range(0, 9) < 7) addr = 32'($urandom_range(0, 1023));
            else if ($urandom_range(0, 2) != 0) addr = BYTE_MASK - 32'($urandom_range(0, 15));
            else addr = $urandom | 32'h00080000;
            wd = $urandom;
            model(st, ty, addr, wd, e_flt, e_rd, e_lat, e_nacc);
            run_op(st, ty, addr, wd, lat, rd, flt);
            chk("rand_latency", 32'(lat), 32'(e_lat));
            chk("rand_fault", 32'(flt), 32'(e_flt));
            chk("rand_rdata", rd, e_rd);
            chk("rand_naccess", 32'(acc_n), 32'(e_nacc));
            if (st && !e_flt) begin
                wa0 = int'((addr >> 2) & (NWORDS - 1));
                wa1 = (wa0 + 1) % NWORDS;
                chk("rand_store_word0", mem_arr[wa0], mem_ref[wa0]);
                chk("rand_store_word1", mem_arr[wa1], mem_ref[wa1]);
            end
        end

        saved = mem_arr[20];
        @(negedge clk);
        acc_n = 0;
        req_valid = 1'b1;
        req_store = 1'b1;
        req_type  = 3'b010;
        req_addr  = 32'h50;
        req_wdata = ~saved;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_acc1_we", 32'(mem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        chk("abort_no_write", mem_arr[20], saved);
        chk("abort_ready_idle", 32'(req_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
